switch_debouncer: RTL and testbench

Conditions the raw Basys3 slide-switch inputs before they reach `top`. Each bit is synchronized into the `clk` domain, filtered so that a level change is accepted only after it has held steady for a programmable number of cycles, and reported as a clean level plus one-cycle rise and fall pulses. `sw_clean` drives `top.sw` directly. The pulses feed downstream sequential logic that must react once per switch flip.

---
 rtl/switch_debouncer.sv | 78 +++++++
 tb/tb_switch_debouncer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-bit two-flop synchronizer, stability filter,
// and registered one-cycle rise/fall pulses coincident with the clean level change.

module switch_debouncer_lane #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES+1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES-1);

  logic             r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clean, r_rise, r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      // Any return to the accepted level restarts the stability count.
      if (r_sync2 == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt != LAST) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_clean <= r_sync2;
        r_cnt   <= '0;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
      end
    end
  end

  assign o_clean = r_clean;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

module switch_debouncer #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    switch_debouncer_lane #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (sw_raw[i]),
      .o_clean (sw_clean[i]),
      .o_rise  (sw_rise[i]),
      .o_fall  (sw_fall[i])
    );
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized scoreboard bench for switch_debouncer: a sample-history reference
// model predicts each cycle's outputs; a negedge monitor pops and compares.

module tb_switch_debouncer;
  localparam int W = 16;
  localparam int S = 4;

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_raw = '1;
  logic [W-1:0] sw_clean, sw_rise, sw_fall;

  int n_checks = 0;
  int n_fail   = 0;

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: hist[0] is the raw value sampled at the previous edge, so the
  // synchronized value seen before this edge is hist[1]. A bit flips when the last
  // S synchronized samples all disagree with its accepted level.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_clean;
  exp_t         sb[$];

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k <= S; k++) hist.push_back('0);
      m_clean = '0;
    end else begin
      for (int b = 0; b < W; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 1; j <= S; j++)
          if (hist[j][b] == m_clean[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_clean[b] = ~m_clean[b];
          e.rise[b]  = m_clean[b];
          e.fall[b]  = ~m_clean[b];
        end
      end
      hist.push_front(sw_raw);
      void'(hist.pop_back());
    end
    e.clean = m_clean;
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty @%0t: got 0 entries expected 1", $time);
    end else begin
      e = sb.pop_front();
      chk("sb_clean", sw_clean, e.clean);
      chk("sb_rise",  sw_rise,  e.rise);
      chk("sb_fall",  sw_fall,  e.fall);
      n_checks++;
      if ((sw_rise & sw_fall) != '0) begin
        n_fail++;
        $display("FAIL pulse_overlap @%0t: got %h expected 0", $time, sw_rise & sw_fall);
      end
    end
  end

  task automatic hold(input logic [W-1:0] v, input int n);
    sw_raw = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rst(input logic v);
    @(negedge clk);
    #1 rst_n = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] v;
    // Reset held with all switches up; outputs must stay cleared.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clean", sw_clean, '0);
    chk("rst_rise",  sw_rise,  '0);
    chk("rst_fall",  sw_fall,  '0);
    #1 rst_n = 1'b1;
    // Independent latency check: clean appears exactly on edge 6 after release.
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("lat_edge5_clean", sw_clean, '0);
    @(negedge clk);
    chk("lat_edge6_clean", sw_clean, '1);
    chk("lat_edge6_rise",  sw_rise,  '1);
    @(negedge clk);
    chk("lat_edge7_rise",  sw_rise,  '0);
    #1;

    hold('0, 10);                              // all released, fall pulses
    hold(16'h0001, 10);                        // clean press on bit 0
    hold(16'h0009, 3); hold(16'h0001, 3);      // bounce on bit 3
    hold(16'h0009, 3); hold(16'h0001, 12);
    hold(16'h0021, 2); hold(16'h0001, 1);      // bounce then settle on bit 5
    hold(16'h0021, 12);
    hold(16'h00F0, 10);                        // multi-bit release/press
    hold(16'h0F00, 10);
    hold(16'h0F80, 4);                         // reset mid-count on bit 7
    set_rst(1'b0); set_rst(1'b0);
    set_rst(1'b1);
    hold(16'h0F80, 12);

    v = '0;
    for (int i = 0; i < 300; i++) begin
      v ^= W'($urandom & $urandom);
      hold(v, $urandom_range(1, 8));
      if ($urandom_range(0, 60) == 0) begin
        set_rst(1'b0);
        set_rst(1'b1);
      end
    end
    hold(v, 10);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
